cpc_io_write_qualifier: RTL and testbench



---
 rtl/cpc_io_write_qualifier.sv | 120 ++++++++++++
 tb/tb_cpc_io_write_qualifier.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cpc_io_write_qualifier.sv
// Synchronous qualifier for Z80 OUT cycles to the gate-array/RAM port: registers the
// strobes, filters short pulses and IRQ-acknowledge, and issues one bank-register load.
module cpc_io_write_qualifier #(
    parameter int          MIN_LOW  = 2,
    parameter logic [1:0]  DATA_TAG = 2'b11
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IOREQ_B,
    input  logic       WR_B,
    input  logic       M1_B,
    input  logic       A15,
    input  logic [7:0] D,
    output logic       bank_wr,
    output logic [5:0] bank_data,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {ARMWAIT, IDLE, COUNT, FIRED} state_t;

    localparam logic [2:0] CNT_LAST = 3'(MIN_LOW - 1);

    logic       ioreq_b_reg, wr_b_reg, m1_b_reg, a15_reg;
    logic [7:0] d_reg;
    logic       primed_reg;
    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [7:0] glitch_cnt_reg, glitch_cnt_next;
    logic       bank_wr_reg, bank_wr_next;
    logic [5:0] bank_data_reg, bank_data_next;

    logic active;
    logic decode_match;
    logic fire;

    assign active       = !ioreq_b_reg && !wr_b_reg && m1_b_reg;
    assign decode_match = !a15_reg && (d_reg[7:6] == DATA_TAG);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ioreq_b_reg    <= 1'b1;
            wr_b_reg       <= 1'b1;
            m1_b_reg       <= 1'b1;
            a15_reg        <= 1'b0;
            d_reg          <= 8'h00;
            primed_reg     <= 1'b0;
            state_reg      <= ARMWAIT;
            cnt_reg        <= 3'd0;
            glitch_cnt_reg <= 8'h00;
            bank_wr_reg    <= 1'b0;
            bank_data_reg  <= 6'h00;
        end else begin
            ioreq_b_reg    <= IOREQ_B;
            wr_b_reg       <= WR_B;
            m1_b_reg       <= M1_B;
            a15_reg        <= A15;
            d_reg          <= D;
            primed_reg     <= 1'b1;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            glitch_cnt_reg <= glitch_cnt_next;
            bank_wr_reg    <= bank_wr_next;
            bank_data_reg  <= bank_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        glitch_cnt_next = glitch_cnt_reg;
        fire            = 1'b0;
        case (state_reg)
            // The input registers hold their idle reset values on the first edge after
            // reset; only a genuinely sampled idle bus may arm, so a strobe that spans
            // reset release is never taken.
            ARMWAIT: begin
                if (primed_reg && !active)
                    state_next = IDLE;
            end
            IDLE: begin
                if (active) begin
                    if (MIN_LOW == 1) begin
                        fire       = 1'b1;
                        state_next = FIRED;
                    end else begin
                        state_next = COUNT;
                        cnt_next   = 3'd1;
                    end
                end
            end
            COUNT: begin
                if (active) begin
                    if (cnt_reg == CNT_LAST) begin
                        fire       = 1'b1;
                        state_next = FIRED;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end else begin
                    if (glitch_cnt_reg != 8'hFF)
                        glitch_cnt_next = glitch_cnt_reg + 8'd1;
                    state_next = IDLE;
                end
            end
            FIRED: begin
                if (!active)
                    state_next = IDLE;
            end
            default: state_next = ARMWAIT;
        endcase

        bank_wr_next   = fire && decode_match;
        bank_data_next = bank_wr_next ? d_reg[5:0] : bank_data_reg;
    end

    assign bank_wr    = bank_wr_reg;
    assign bank_data  = bank_data_reg;
    assign glitch_cnt = glitch_cnt_reg;

endmodule

// File: tb/tb_cpc_io_write_qualifier.sv
// Directed bench for cpc_io_write_qualifier: two instances (MIN_LOW=2 and 3) share the
// stimulus and are checked every cycle against a run-length model of the OUT cycle.
module tb_cpc_io_write_qualifier;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       IOREQ_B = 1'b1, WR_B = 1'b1, M1_B = 1'b1, A15 = 1'b0;
    logic [7:0] D = 8'h00;

    logic       bank_wr2, bank_wr3;
    logic [5:0] bank_data2, bank_data3;
    logic [7:0] glitch_cnt2, glitch_cnt3;

    int vectors = 0;
    int miscompares = 0;
    int pulses2 = 0;
    int pulses3 = 0;

    always #5 CLK = ~CLK;

    cpc_io_write_qualifier #(.MIN_LOW(2), .DATA_TAG(2'b11)) dut2 (
        .CLK(CLK), .RESET(RESET), .IOREQ_B(IOREQ_B), .WR_B(WR_B), .M1_B(M1_B),
        .A15(A15), .D(D), .bank_wr(bank_wr2), .bank_data(bank_data2),
        .glitch_cnt(glitch_cnt2)
    );

    cpc_io_write_qualifier #(.MIN_LOW(3), .DATA_TAG(2'b11)) dut3 (
        .CLK(CLK), .RESET(RESET), .IOREQ_B(IOREQ_B), .WR_B(WR_B), .M1_B(M1_B),
        .A15(A15), .D(D), .bank_wr(bank_wr3), .bank_data(bank_data3),
        .glitch_cnt(glitch_cnt3)
    );

    // Model: count consecutive qualifying samples as the core sees them (one edge late).
    // The MIN_LOW-th one fires; a run that ends short of MIN_LOW is a glitch.
    int         min_low [2] = '{2, 3};
    int         run [2] = '{0, 0};
    bit         armed [2] = '{0, 0};
    bit         exp_wr [2] = '{0, 0};
    logic [5:0] exp_data [2] = '{6'h00, 6'h00};
    int         exp_glitch [2] = '{0, 0};
    bit         seen_valid = 0;
    bit         seen_active = 0;
    logic       seen_a15 = 1'b0;
    logic [7:0] seen_d = 8'h00;

    initial begin
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                for (int i = 0; i < 2; i++) begin
                    run[i] = 0; armed[i] = 0; exp_wr[i] = 0;
                    exp_data[i] = 6'h00; exp_glitch[i] = 0;
                end
                seen_valid = 0; seen_active = 0; seen_a15 = 1'b0; seen_d = 8'h00;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    exp_wr[i] = 0;
                    if (!armed[i]) begin
                        if (seen_valid && !seen_active) armed[i] = 1;
                    end else if (seen_active) begin
                        run[i] = run[i] + 1;
                        if (run[i] == min_low[i] && !seen_a15 && seen_d[7:6] == 2'b11) begin
                            exp_wr[i] = 1;
                            exp_data[i] = seen_d[5:0];
                        end
                    end else begin
                        if (run[i] > 0 && run[i] < min_low[i] && exp_glitch[i] < 255)
                            exp_glitch[i] = exp_glitch[i] + 1;
                        run[i] = 0;
                    end
                end
                seen_valid  = 1;
                seen_active = !IOREQ_B && !WR_B && M1_B;
                seen_a15    = A15;
                seen_d      = D;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            chk("bank_wr[ML2]", int'(bank_wr2), int'(exp_wr[0]));
            chk("bank_data[ML2]", int'(bank_data2), int'(exp_data[0]));
            chk("glitch_cnt[ML2]", int'(glitch_cnt2), exp_glitch[0]);
            chk("bank_wr[ML3]", int'(bank_wr3), int'(exp_wr[1]));
            chk("bank_data[ML3]", int'(bank_data3), int'(exp_data[1]));
            chk("glitch_cnt[ML3]", int'(glitch_cnt3), exp_glitch[1]);
            if (bank_wr2) pulses2 = pulses2 + 1;
            if (bank_wr3) pulses3 = pulses3 + 1;
        end
    end

    // Holds the given bus state for n sampling edges; values change 3 time units after an edge.
    task automatic drive(input logic io, input logic wr, input logic m1, input logic a,
                         input logic [7:0] d, input int n);
        @(posedge CLK);
        #3;
        IOREQ_B = io; WR_B = wr; M1_B = m1; A15 = a; D = d;
        repeat (n - 1) @(posedge CLK);
    endtask

    task automatic idle(input int n);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, n);
    endtask

    task automatic out_cycle(input logic a, input logic [7:0] d, input int n);
        drive(1'b0, 1'b0, 1'b1, a, d, n);
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    int p2_snap;

    initial begin
        repeat (3) @(posedge CLK);
        #3 RESET = 1'b0;
        settle();
        chk("reset bank_wr", int'(bank_wr2), 0);
        chk("reset bank_data", int'(bank_data2), 0);
        chk("reset glitch_cnt", int'(glitch_cnt2), 0);
        idle(3);

        // basic write
        out_cycle(1'b0, 8'hC5, 3);
        idle(3);
        settle();
        chk("basic pulses", pulses2, 1);
        chk("basic bank_data", int'(bank_data2), 'h05);
        chk("basic glitch_cnt", int'(glitch_cnt2), 0);

        // decode rejects
        out_cycle(1'b1, 8'hC5, 3);
        idle(3);
        out_cycle(1'b0, 8'h85, 3);
        idle(3);
        settle();
        chk("reject pulses", pulses2, 1);
        chk("reject bank_data", int'(bank_data2), 'h05);

        // interrupt acknowledge
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 4);
        idle(3);
        settle();
        chk("intack pulses", pulses2, 1);
        chk("intack glitch_cnt", int'(glitch_cnt2), 0);

        // long strobe, then back-to-back after a single idle sample
        out_cycle(1'b0, 8'hC3, 10);
        idle(1);
        settle();
        chk("long pulses", pulses2, 2);
        chk("long bank_data", int'(bank_data2), 'h03);
        out_cycle(1'b0, 8'hC7, 3);
        idle(3);
        settle();
        chk("b2b pulses", pulses2, 3);
        chk("b2b bank_data", int'(bank_data2), 'h07);

        // glitches on the MIN_LOW=3 instance
        out_cycle(1'b0, 8'hC9, 2);
        idle(3);
        settle();
        chk("glitch1 glitch_cnt[ML3]", int'(glitch_cnt3), 1);
        chk("glitch1 bank_data[ML3]", int'(bank_data3), 'h07);
        repeat (299) begin
            out_cycle(1'b0, 8'hC9, 2);
            idle(1);
        end
        idle(3);
        settle();
        chk("glitch sat glitch_cnt[ML3]", int'(glitch_cnt3), 255);
        chk("glitch sat glitch_cnt[ML2]", int'(glitch_cnt2), 0);

        // reset while counting, released with the strobe still held
        p2_snap = pulses2;
        out_cycle(1'b0, 8'hC5, 2);
        @(posedge CLK);
        #3 RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b0;
        repeat (5) @(posedge CLK);
        settle();
        chk("rst-mid pulses", pulses2 - p2_snap, 0);
        chk("rst-mid bank_data", int'(bank_data2), 0);
        chk("rst-mid glitch_cnt[ML3]", int'(glitch_cnt3), 0);
        idle(1);
        out_cycle(1'b0, 8'hC1, 3);
        idle(3);
        settle();
        chk("post-rst pulses", pulses2 - p2_snap, 1);
        chk("post-rst bank_data", int'(bank_data2), 'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
